// File: rtl/ifetch_stage.sv
// Fetch stage: owns pc, reads the combinational ROM, and registers the word into IF/ID (1-cycle latency).
// Decode backpressure via id_ready holds pc and IF/ID; redirects flush regardless; faults halt until rst.
module ifetch_stage #(
  parameter int unsigned SIZE     = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [SIZE-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [31:0]     redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [31:0]     if_pc,
  output logic [31:0]     if_pc_plus4,
  output logic [31:0]     fetch_pc,
  output logic            if_fault,
  output logic [1:0]      fault_cause,
  output logic [31:0]     fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        load;
  logic        out_of_range;

  assign load         = !if_valid || id_ready;
  assign out_of_range = (pc >> (SIZE + 2)) != 32'd0;
  assign imem_addr    = pc[SIZE+1:2];
  assign fetch_pc     = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd0;
      if_fault    <= 1'b0;
      fault_cause <= 2'b00;
      fetch_count <= 32'd0;
    end else if (state == RUN) begin
      if (redirect_valid) begin
        // Flush overrides a stall; targets are range-checked once they become pc.
        if_valid <= 1'b0;
        pc       <= redirect_pc;
        if (redirect_pc[1:0] != 2'b00) begin
          state       <= HALT;
          if_fault    <= 1'b1;
          fault_cause <= 2'b01;
        end
      end else if (load) begin
        if (out_of_range) begin
          state       <= HALT;
          if_fault    <= 1'b1;
          fault_cause <= 2'b10;
          if_valid    <= 1'b0;
        end else begin
          if_instr    <= imem_data;
          if_pc       <= pc;
          if_pc_plus4 <= pc + 32'd4;
          if_valid    <= 1'b1;
          pc          <= pc + 32'd4;
          fetch_count <= fetch_count + 32'd1;
        end
      end
    end else begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the rv32 three-stage pipeline. It owns the program counter, drives the word address of the combinational instruction ROM, and registers the returned word into the IF/ID pipeline register. It supports decode backpressure, branch/jump redirects from execute, and a sticky fault halt for misaligned or out-of-range fetch targets.

## Interface
- SIZE, 10, ROM word-address width; ROM holds 2**SIZE words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  SIZE  ROM word address; equals pc[SIZE+1:2], combinational from pc.
- imem_data  in  32  ROM word for imem_addr, valid in the same cycle.
- id_ready  in  1  decode accepts IF/ID contents this cycle.
- redirect_valid  in  1  execute redirect request (taken branch, jal, jalr).
- redirect_pc  in  32  redirect target byte address.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  32  registered instruction.
- if_pc  out  32  byte address of if_instr.
- if_pc_plus4  out  32  if_pc + 4, for link values.
- fetch_pc  out  32  current pc register.
- if_fault  out  1  sticky fault flag.
- fault_cause  out  2  2'b01 misaligned target, 2'b10 out of range, 2'b00 none.
- fetch_count  out  32  count of instructions loaded into IF/ID with valid=1.

## Operation
- Two states, RUN and HALT. Reset enters RUN.
- Reset values: pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, if_fault=0, fault_cause=0, fetch_count=0.
- Load enable: load = !if_valid || id_ready.
- Out-of-range test: pc[31:SIZE+2] != 0.
- Per-cycle priority in RUN: rst > redirect > fault check > load > hold.
- **Redirect** (redirect_valid=1):
  - if_valid <= 0. This flush overrides a stall.
  - pc <= redirect_pc.
  - If redirect_pc[1:0] != 0: enter HALT, if_fault <= 1, fault_cause <= 01.
  - Redirect targets are not range-checked here. The range check runs when the target becomes pc.
- **Fault check** (no redirect, pc out of range, load=1):
  - Enter HALT, if_fault <= 1, fault_cause <= 10, if_valid <= 0.
  - pc holds.
- **Load** (no redirect, pc in range, load=1):
  - if_instr <= imem_data, if_pc <= pc, if_pc_plus4 <= pc+4, if_valid <= 1.
  - pc <= pc+4.
  - fetch_count <= fetch_count+1, wrapping mod 2**32.
- **Hold** (load=0, no redirect): pc and IF/ID unchanged.
- **HALT**:
  - if_valid <= 0 on entry. If IF/ID was already valid when HALT is entered from the fault check, it has already been flushed.
  - pc, fetch_count and fault fields frozen.
  - redirect_valid ignored. Exit only via rst.
- pc+4 arithmetic is 32-bit and wraps. Wrap past 2**(SIZE+2) is caught by the range check on the next load.

## Timing
- ROM access is combinational. Fetch-to-IF/ID latency is 1 cycle: pc presented in cycle N gives if_instr valid from cycle N+1.
- Steady state with id_ready=1: one instruction per cycle.
- Redirect asserted in cycle N: if_valid=0 in N+1; target instruction valid in N+2 (one bubble).
- Stall: while if_valid=1 and id_ready=0, all IF/ID outputs are stable.
- Redirect and stall in the same cycle: redirect wins. The bubble is inserted regardless of id_ready.
- rst asserted mid-stall, mid-redirect or in HALT: the next cycle shows reset values, state RUN, imem_addr=RESET_PC[SIZE+1:2].
- First valid instruction appears on the second rising edge after rst falls.

## Test plan
- **Sequential fetch.** ROM word k = k, RESET_PC=0, id_ready=1, 5 cycles after reset.
  - Required: if_instr 0,1,2,3; if_pc 0,4,8,12; fetch_count=4.
- **Stall.** Hold id_ready=0 for 3 cycles while if_pc=8.
  - Required: if_instr/if_pc frozen at word 2 / 8; fetch_pc=12 constant.
  - Releasing id_ready gives if_pc=12 the next cycle.
- **Redirect with stall.** redirect_valid=1, redirect_pc=0x40 in the same cycle as id_ready=0.
  - Required: if_valid=0 next cycle, then if_pc=0x40 with if_instr=word 16; fetch_count has no increment for the bubble.
- **Misaligned redirect.** redirect_pc=0x42.
  - Required: if_fault=1, fault_cause=01, if_valid=0 permanently; a later redirect to 0x0 is ignored.
  - rst clears the fault, and fetch resumes at 0.
- **Out of range.** SIZE=2, sequential fetch from 0.
  - Required: words at 0,4,8,12 valid; at pc=16 the stage enters HALT with fault_cause=10, fetch_count=4.
- **Reset in HALT.** Assert rst while in HALT.
  - Required: all outputs equal reset values one cycle later.
